// File: rtl/custom_sync_fifo.sv
// rtl/custom_sync_fifo.sv - single-clock FIFO with flags, ack/err pulses, count and flush; SYNC_FIFO_FWFT_EN selects first-word-fall-through
module custom_sync_fifo #(
   parameter int SIZE      = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2,
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            clr,
   input  logic            wen,
   input  logic [SIZE-1:0] din,
   input  logic            ren,
   output logic [SIZE-1:0] dout,
   output logic            fifo_full,
   output logic            fifo_empty,
   output logic            fifo_almost_full,
   output logic            fifo_almost_empty,
   output logic [CW-1:0]   fifo_count,
   output logic            wr_ack,
   output logic            wr_err,
   output logic            rd_ack,
   output logic            rd_err
);

   localparam int AW = $clog2(DEPTH);

   logic [SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic            wr_acc;
   logic            rd_acc;

   // Acceptance and flags are all decided from the registered count; clr overrides requests.
   always_comb begin
      fifo_full         = (count == CW'(DEPTH));
      fifo_empty        = (count == '0);
      fifo_almost_full  = (count >= CW'(AF_THRESH));
      fifo_almost_empty = (count <= CW'(AE_THRESH));
      fifo_count        = count;
      wr_acc            = wen & ~fifo_full & ~clr;
      rd_acc            = ren & ~fifo_empty & ~clr;
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (wr_acc) begin
         mem[wptr] <= din;
      end
   end

   // Pointers and occupancy; pointers wrap freely since count alone tracks fullness.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + AW'(1);
         if (rd_acc) rptr <= rptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Handshake pulses report the previous cycle's request outcome; a flush reports nothing.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ack <= 1'b0;
         wr_err <= 1'b0;
         rd_ack <= 1'b0;
         rd_err <= 1'b0;
      end else begin
         wr_ack <= wr_acc;
         wr_err <= wen & fifo_full & ~clr;
         rd_ack <= rd_acc;
         rd_err <= ren & fifo_empty & ~clr;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented continuously; zero while empty so reset state reads as 0.
   always_comb begin
      dout = fifo_empty ? '0 : mem[rptr];
   end
`else
   // Registered read port: loads the head word on an accepted read, otherwise holds.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dout <= '0;
      end else if (rd_acc) begin
         dout <= mem[rptr];
      end
   end
`endif

endmodule

// File: tb/tb_custom_sync_fifo.sv
// tb/tb_custom_sync_fifo.sv - self-checking bench for custom_sync_fifo with queue-based reference model
module tb_custom_sync_fifo;

   localparam int SIZE  = 32;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk_i = 1'b0;
   logic            rst_n_i = 1'b0;
   logic            clr = 1'b0;
   logic            wen = 1'b0;
   logic [SIZE-1:0] din = '0;
   logic            ren = 1'b0;
   logic [SIZE-1:0] dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_almost_full;
   logic            fifo_almost_empty;
   logic [CW-1:0]   fifo_count;
   logic            wr_ack;
   logic            wr_err;
   logic            rd_ack;
   logic            rd_err;

   int n_checks = 0;
   int n_fail   = 0;

   custom_sync_fifo dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .clr               (clr),
      .wen               (wen),
      .din               (din),
      .ren               (ren),
      .dout              (dout),
      .fifo_full         (fifo_full),
      .fifo_empty        (fifo_empty),
      .fifo_almost_full  (fifo_almost_full),
      .fifo_almost_empty (fifo_almost_empty),
      .fifo_count        (fifo_count),
      .wr_ack            (wr_ack),
      .wr_err            (wr_err),
      .rd_ack            (rd_ack),
      .rd_err            (rd_err)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: an ordered queue of stored words plus last-cycle outcome bits.
   logic [SIZE-1:0] q[$];
   logic [SIZE-1:0] m_dout_reg;
   bit m_wack, m_werr, m_rack, m_rerr;

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q.delete();
         m_dout_reg = '0;
         m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
      end else begin
         int sz;
         bit wa, ra;
         sz = q.size();
         if (clr) begin
            q.delete();
            m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
         end else begin
            wa = wen && (sz < DEPTH);
            ra = ren && (sz > 0);
            m_werr = wen && (sz == DEPTH);
            m_rerr = ren && (sz == 0);
            m_wack = wa;
            m_rack = ra;
            if (ra) m_dout_reg = q.pop_front();
            if (wa) q.push_back(din);
         end
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk_i) begin
      int sz;
      sz = q.size();
      chk("fifo_count",        64'(fifo_count),        64'(sz));
      chk("fifo_empty",        64'(fifo_empty),        64'(sz == 0));
      chk("fifo_full",         64'(fifo_full),         64'(sz == DEPTH));
      chk("fifo_almost_empty", 64'(fifo_almost_empty), 64'(sz <= 2));
      chk("fifo_almost_full",  64'(fifo_almost_full),  64'(sz >= 14));
      chk("wr_ack", 64'(wr_ack), 64'(m_wack));
      chk("wr_err", 64'(wr_err), 64'(m_werr));
      chk("rd_ack", 64'(rd_ack), 64'(m_rack));
      chk("rd_err", 64'(rd_err), 64'(m_rerr));
`ifdef SYNC_FIFO_FWFT_EN
      if (sz > 0) chk("dout_fwft", 64'(dout), 64'(q[0]));
`else
      chk("dout", 64'(dout), 64'(m_dout_reg));
`endif
   end

   task automatic cyc(input bit w, input logic [SIZE-1:0] d, input bit r, input bit c);
      wen = w; din = d; ren = r; clr = c;
      @(posedge clk_i);
      #1;
      wen = 0; ren = 0; clr = 0;
   endtask

   initial begin
      // 1: reset and idle
      rst_n_i = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1;
      repeat (3) cyc(0, '0, 0, 0);
      chk("t1_empty", 64'(fifo_empty), 64'd1);
      chk("t1_ae", 64'(fifo_almost_empty), 64'd1);
      chk("t1_full", 64'(fifo_full), 64'd0);
      chk("t1_count", 64'(fifo_count), 64'd0);
      chk("t1_dout", 64'(dout), 64'd0);
      chk("t1_pulses", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'd0);

      // 2: fill with 1..16 then one rejected write
      for (int i = 1; i <= 16; i++) begin
         cyc(1, SIZE'(i), 0, 0);
         chk("t2_wr_ack", 64'(wr_ack), 64'd1);
         chk("t2_count", 64'(fifo_count), 64'(i));
         chk("t2_ae", 64'(fifo_almost_empty), 64'(i <= 2));
         chk("t2_af", 64'(fifo_almost_full), 64'(i >= 14));
         chk("t2_full", 64'(fifo_full), 64'(i == 16));
      end
      cyc(1, 32'd99, 0, 0);
      chk("t2_wr_err", 64'(wr_err), 64'd1);
      chk("t2_no_ack", 64'(wr_ack), 64'd0);
      chk("t2_count16", 64'(fifo_count), 64'd16);

      // 3: drain, expecting 1..16 in order, then one rejected read
      for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         chk("t3_dout", 64'(dout), 64'(i));
         cyc(0, '0, 1, 0);
`else
         cyc(0, '0, 1, 0);
         chk("t3_dout", 64'(dout), 64'(i));
`endif
         chk("t3_rd_ack", 64'(rd_ack), 64'd1);
      end
      chk("t3_empty", 64'(fifo_empty), 64'd1);
      cyc(0, '0, 1, 0);
      chk("t3_rd_err", 64'(rd_err), 64'd1);
      chk("t3_no_ack", 64'(rd_ack), 64'd0);

      // 4: simultaneous requests at full and at empty
      for (int i = 0; i < 16; i++) cyc(1, SIZE'(32'h100 + i), 0, 0);
      cyc(1, 32'h1ff, 1, 0);
      chk("t4_rd_ack", 64'(rd_ack), 64'd1);
      chk("t4_wr_err", 64'(wr_err), 64'd1);
      chk("t4_count15", 64'(fifo_count), 64'd15);
      for (int i = 0; i < 15; i++) cyc(0, '0, 1, 0);
      chk("t4_empty", 64'(fifo_empty), 64'd1);
      cyc(1, 32'h77, 1, 0);
      chk("t4_wr_ack", 64'(wr_ack), 64'd1);
      chk("t4_rd_err", 64'(rd_err), 64'd1);
      chk("t4_count1", 64'(fifo_count), 64'd1);
      cyc(0, '0, 1, 0);

      // 5: flush wins over a concurrent write, then a single word round trip
      for (int i = 0; i < 10; i++) cyc(1, SIZE'(32'h200 + i), 0, 0);
      chk("t5_count10", 64'(fifo_count), 64'd10);
      cyc(1, 32'h3ff, 0, 1);
      chk("t5_count0", 64'(fifo_count), 64'd0);
      chk("t5_empty", 64'(fifo_empty), 64'd1);
      chk("t5_no_wr_ack", 64'(wr_ack), 64'd0);
      cyc(1, 32'hA5, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("t5_dout_a5", 64'(dout), 64'hA5);
      cyc(0, '0, 1, 0);
`else
      cyc(0, '0, 1, 0);
      chk("t5_dout_a5", 64'(dout), 64'hA5);
`endif

      // 6: interleaved stream wrapping the pointers, reset pulsed part way
      for (int i = 0; i < 40; i++) begin
         cyc(1, SIZE'(32'h1000 + i), i >= 4, 0);
         if (i == 25) begin
            #2 rst_n_i = 0;
            #1;
            chk("t6_rst_empty", 64'(fifo_empty), 64'd1);
            chk("t6_rst_count", 64'(fifo_count), 64'd0);
            chk("t6_rst_full", 64'(fifo_full), 64'd0);
            chk("t6_rst_ae", 64'(fifo_almost_empty), 64'd1);
            chk("t6_rst_af", 64'(fifo_almost_full), 64'd0);
            chk("t6_rst_dout", 64'(dout), 64'd0);
            chk("t6_rst_pulses", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'd0);
            @(posedge clk_i);
            #1 rst_n_i = 1;
         end
      end
      for (int i = 0; i < 6; i++) cyc(0, '0, 1, 0);
      chk("t6_drained", 64'(fifo_empty), 64'd1);

      repeat (2) cyc(0, '0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
